// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath slice: PC, IR, MAR, MDR, Y, 64-bit Z and R1-R3
// exchanging data over one shared combinational bus. Every strobe comes from an
// external control sequencer; this block holds no sequencing state of its own.
module cpu_datapath #(
    parameter int DATA_W = 32
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  PCout,
    input  logic                  Zlowout,
    input  logic                  MDRout,
    input  logic                  R2out,
    input  logic                  R3out,
    input  logic                  MARin,
    input  logic                  Zin,
    input  logic                  PCin,
    input  logic                  MDRin,
    input  logic                  IRin,
    input  logic                  Yin,
    input  logic                  IncPC,
    input  logic                  Read,
    input  logic                  AND,
    input  logic                  R1in,
    input  logic                  R2in,
    input  logic                  R3in,
    input  logic [DATA_W-1:0]     Mdatain,
    output logic [DATA_W-1:0]     BusOut,
    output logic [DATA_W-1:0]     PC_q,
    output logic [DATA_W-1:0]     IR_q,
    output logic [DATA_W-1:0]     MAR_q,
    output logic [DATA_W-1:0]     MDR_q,
    output logic [DATA_W-1:0]     Y_q,
    output logic [DATA_W-1:0]     R1_q,
    output logic [DATA_W-1:0]     R2_q,
    output logic [DATA_W-1:0]     R3_q,
    output logic [2*DATA_W-1:0]   Z_q
);

    logic [DATA_W-1:0]   bus;
    logic [DATA_W-1:0]   mdr_src;
    logic [2*DATA_W-1:0] alu_result;

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    // Bus source select: fixed priority so overlapping out strobes never fight.
    always_comb begin
        bus = '0;
        if (PCout)
            bus = PC_q;
        else if (Zlowout)
            bus = Z_q[DATA_W-1:0];
        else if (MDRout)
            bus = MDR_q;
        else if (R2out)
            bus = R2_q;
        else if (R3out)
            bus = R3_q;
    end

    assign BusOut = bus;

    // MDR input mux: memory data on a read cycle, otherwise whatever is on the bus.
    assign mdr_src = Read ? Mdatain : bus;

    // ALU: operand A is Y, operand B is the bus; AND wins over increment.
    always_comb begin
        alu_result = {{DATA_W{1'b0}}, bus};
        if (AND)
            alu_result = {{DATA_W{1'b0}}, Y_q & bus};
        else if (IncPC)
            alu_result = {{DATA_W{1'b0}}, bus + ONE};
    end

    // Register file: each enabled register captures its source on the rising edge;
    // reset clears everything at once, regardless of strobes.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            PC_q  <= '0;
            IR_q  <= '0;
            MAR_q <= '0;
            MDR_q <= '0;
            Y_q   <= '0;
            Z_q   <= '0;
            R1_q  <= '0;
            R2_q  <= '0;
            R3_q  <= '0;
        end else begin
            if (PCin)  PC_q  <= bus;
            if (IRin)  IR_q  <= bus;
            if (MARin) MAR_q <= bus;
            if (MDRin) MDR_q <= mdr_src;
            if (Yin)   Y_q   <= bus;
            if (Zin)   Z_q   <= alu_result;
            if (R1in)  R1_q  <= bus;
            if (R2in)  R2_q  <= bus;
            if (R3in)  R3_q  <= bus;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Table-driven bench for cpu_datapath: each vector drives one cycle of strobes,
// checks the combinational bus before the edge and one register after it.
module tb_cpu_datapath;

    localparam int W = 32;

    // Strobe bit positions inside the packed control word.
    localparam logic [16:0] PCOUT   = 17'd1 << 0;
    localparam logic [16:0] ZLOWOUT = 17'd1 << 1;
    localparam logic [16:0] MDROUT  = 17'd1 << 2;
    localparam logic [16:0] R2OUT   = 17'd1 << 3;
    localparam logic [16:0] R3OUT   = 17'd1 << 4;
    localparam logic [16:0] MARIN   = 17'd1 << 5;
    localparam logic [16:0] ZIN     = 17'd1 << 6;
    localparam logic [16:0] PCIN    = 17'd1 << 7;
    localparam logic [16:0] MDRIN   = 17'd1 << 8;
    localparam logic [16:0] IRIN    = 17'd1 << 9;
    localparam logic [16:0] YIN     = 17'd1 << 10;
    localparam logic [16:0] INCPC   = 17'd1 << 11;
    localparam logic [16:0] READ    = 17'd1 << 12;
    localparam logic [16:0] ANDOP   = 17'd1 << 13;
    localparam logic [16:0] R1IN    = 17'd1 << 14;
    localparam logic [16:0] R2IN    = 17'd1 << 15;
    localparam logic [16:0] R3IN    = 17'd1 << 16;
    localparam logic [16:0] NONE    = 17'd0;

    localparam int S_PC = 0, S_IR = 1, S_MAR = 2, S_MDR = 3, S_Y = 4;
    localparam int S_Z = 5, S_R1 = 6, S_R2 = 7, S_R3 = 8;

    typedef struct {
        logic [16:0]    ctrl;
        logic [W-1:0]   md;
        logic [W-1:0]   exp_bus;
        int             sel;
        logic [2*W-1:0] exp_val;
    } vec_t;

    vec_t vt[$];

    logic           Clock;
    logic           Resetn;
    logic [16:0]    ctrl;
    logic [W-1:0]   Mdatain;
    logic [W-1:0]   BusOut, PC_q, IR_q, MAR_q, MDR_q, Y_q, R1_q, R2_q, R3_q;
    logic [2*W-1:0] Z_q;

    int n_vec;
    int n_err;

    cpu_datapath #(.DATA_W(W)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .PCout(ctrl[0]), .Zlowout(ctrl[1]), .MDRout(ctrl[2]), .R2out(ctrl[3]),
        .R3out(ctrl[4]), .MARin(ctrl[5]), .Zin(ctrl[6]), .PCin(ctrl[7]),
        .MDRin(ctrl[8]), .IRin(ctrl[9]), .Yin(ctrl[10]), .IncPC(ctrl[11]),
        .Read(ctrl[12]), .AND(ctrl[13]), .R1in(ctrl[14]), .R2in(ctrl[15]),
        .R3in(ctrl[16]), .Mdatain(Mdatain), .BusOut(BusOut),
        .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q), .MDR_q(MDR_q), .Y_q(Y_q),
        .R1_q(R1_q), .R2_q(R2_q), .R3_q(R3_q), .Z_q(Z_q)
    );

    // Clock generation.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [2*W-1:0] get_reg(input int sel);
        case (sel)
            S_PC:    return {32'h0, PC_q};
            S_IR:    return {32'h0, IR_q};
            S_MAR:   return {32'h0, MAR_q};
            S_MDR:   return {32'h0, MDR_q};
            S_Y:     return {32'h0, Y_q};
            S_Z:     return Z_q;
            S_R1:    return {32'h0, R1_q};
            S_R2:    return {32'h0, R2_q};
            default: return {32'h0, R3_q};
        endcase
    endfunction

    function automatic string reg_name(input int sel);
        case (sel)
            S_PC:    return "PC";
            S_IR:    return "IR";
            S_MAR:   return "MAR";
            S_MDR:   return "MDR";
            S_Y:     return "Y";
            S_Z:     return "Z";
            S_R1:    return "R1";
            S_R2:    return "R2";
            default: return "R3";
        endcase
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [16:0] c, input logic [W-1:0] md, input logic [W-1:0] eb,
                       input int sel, input logic [2*W-1:0] ev);
        vec_t v;
        v.ctrl = c; v.md = md; v.exp_bus = eb; v.sel = sel; v.exp_val = ev;
        vt.push_back(v);
    endtask

    task automatic check_all_zero(input string tag);
        for (int s = 0; s <= S_R3; s++)
            check($sformatf("%s_%s", tag, reg_name(s)), get_reg(s), '0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Register transfers from memory into R1-R3.
        add(READ | MDRIN,          32'h12, 32'h0,  S_MDR, 64'h12);
        add(MDROUT | R2IN,         32'h0,  32'h12, S_R2,  64'h12);
        add(READ | MDRIN,          32'h14, 32'h0,  S_MDR, 64'h14);
        add(MDROUT | R3IN,         32'h0,  32'h14, S_R3,  64'h14);
        add(READ | MDRIN,          32'h18, 32'h0,  S_MDR, 64'h18);
        add(MDROUT | R1IN,         32'h0,  32'h18, S_R1,  64'h18);
        // Instruction fetch T0-T2.
        add(PCOUT | MARIN | INCPC | ZIN, 32'h0, 32'h0, S_Z, 64'h1);
        add(ZLOWOUT | PCIN | READ | MDRIN, 32'h28918000, 32'h1, S_PC, 64'h1);
        add(NONE,                  32'h0,  32'h0,  S_MDR, 64'h28918000);
        add(MDROUT | IRIN,         32'h0,  32'h28918000, S_IR, 64'h28918000);
        add(PCOUT | MARIN,         32'h0,  32'h1,  S_MAR, 64'h1);
        // AND R1,R2,R3 T3-T5.
        add(R2OUT | YIN,           32'h0,  32'h12, S_Y,   64'h12);
        add(R3OUT | ANDOP | ZIN,   32'h0,  32'h14, S_Z,   64'h10);
        add(ZLOWOUT | R1IN,        32'h0,  32'h10, S_R1,  64'h10);
        // Bus priority chain.
        add(READ | MDRIN,          32'hABCD, 32'h0, S_MDR, 64'hABCD);
        add(PCOUT | MDROUT | R3IN, 32'h0,  32'h1,  S_R3,  64'h1);
        add(ZLOWOUT | MDROUT | R2IN, 32'h0, 32'h10, S_R2, 64'h10);
        add(MDROUT | R2OUT | R3OUT | YIN, 32'h0, 32'hABCD, S_Y, 64'hABCD);
        add(R2OUT | R3OUT | YIN,   32'h0,  32'h10, S_Y,   64'h10);
        // AND beats IncPC; pass-through with no ALU op.
        add(READ | MDRIN,          32'hF0, 32'h0,  S_MDR, 64'hF0);
        add(MDROUT | YIN,          32'h0,  32'hF0, S_Y,   64'hF0);
        add(READ | MDRIN,          32'h3C, 32'h0,  S_MDR, 64'h3C);
        add(MDROUT | ANDOP | INCPC | ZIN, 32'h0, 32'h3C, S_Z, 64'h30);
        add(MDROUT | ZIN,          32'h0,  32'h3C, S_Z,   64'h3C);
        // Broadcast load into several registers at once.
        add(ZLOWOUT | R1IN | R2IN | R3IN, 32'h0, 32'h3C, S_R2, 64'h3C);
        add(NONE,                  32'h0,  32'h0,  S_R1,  64'h3C);
        add(NONE,                  32'h0,  32'h0,  S_R3,  64'h3C);
        // Increment wrap and Read without MDRin.
        add(READ | MDRIN,          32'hFFFFFFFF, 32'h0, S_MDR, 64'hFFFFFFFF);
        add(MDROUT | PCIN,         32'h0,  32'hFFFFFFFF, S_PC, 64'hFFFFFFFF);
        add(PCOUT | INCPC | ZIN,   32'h0,  32'hFFFFFFFF, S_Z, 64'h0);
        add(READ,                  32'h55, 32'h0,  S_MDR, 64'hFFFFFFFF);

        // Reset with every strobe held high.
        Resetn  = 1'b0;
        ctrl    = '1;
        Mdatain = 32'hDEADBEEF;
        repeat (2) @(posedge Clock);
        #1;
        check_all_zero("reset");
        check("reset_bus", {32'h0, BusOut}, '0);
        @(negedge Clock);
        ctrl    = NONE;
        Mdatain = '0;
        Resetn  = 1'b1;

        // Apply the vector table.
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge Clock);
            ctrl    = vt[i].ctrl;
            Mdatain = vt[i].md;
            #1;
            check($sformatf("v%0d_bus", i), {32'h0, BusOut}, {32'h0, vt[i].exp_bus});
            @(posedge Clock);
            #1;
            check($sformatf("v%0d_%s", i, reg_name(vt[i].sel)), get_reg(vt[i].sel), vt[i].exp_val);
        end

        // Asynchronous reset in the middle of a load: registers clear before any edge.
        @(negedge Clock);
        ctrl    = READ | MDRIN | PCOUT | R1IN | ZIN | INCPC;
        Mdatain = 32'h77;
        #2;
        Resetn = 1'b0;
        #1;
        check_all_zero("async");
        @(posedge Clock);
        #1;
        check("async_hold_MDR", {32'h0, MDR_q}, '0);
        @(negedge Clock);
        ctrl   = NONE;
        Resetn = 1'b1;

        // Datapath works again after reset release.
        ctrl    = READ | MDRIN;
        Mdatain = 32'h99;
        @(posedge Clock);
        #1;
        check("post_reset_MDR", {32'h0, MDR_q}, 64'h99);
        @(negedge Clock);
        ctrl = NONE;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
